// File: rtl/proximity_filter.sv
// proximity_filter: smooths completed ultrasonic distance samples with a
// power-of-two moving-average window and drives a debounced, hysteretic
// proximity alarm (near) with a one-cycle change pulse (near_changed).
//
// Optional feature macro: PROX_FILTER_MISS_FLUSH_EN
//   defined     - MISS_LIMIT consecutive zero (no-echo) samples flush the filter
//   not defined - zero samples are silently discarded and never flush
module proximity_filter #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter logic [7:0]  NEAR_CM    = 8'd30,
  parameter logic [7:0]  FAR_CM     = 8'd35,
  parameter int unsigned HOLD       = 3,
  parameter int unsigned MISS_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] distance,
  input  logic       clear,
  output logic       avg_valid,
  output logic [7:0] avg_distance,
  output logic       near,
  output logic       near_changed
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam int unsigned SUM_W     = DEPTH_LOG2 + 8;
  localparam int unsigned CNT_W     = DEPTH_LOG2 + 1;
  localparam int unsigned PTR_W     = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
  localparam logic [3:0]  HOLD_LAST = 4'(HOLD - 1);

  typedef enum logic {
    ST_FAR  = 1'b0,
    ST_NEAR = 1'b1
  } state_e;

  // Elaboration-time sanity check of the configuration.
  if (HOLD < 1 || HOLD > 15 || MISS_LIMIT < 1 || MISS_LIMIT > 15 ||
      FAR_CM <= NEAR_CM) begin : g_param_check
    $error("proximity_filter: parameter out of range");
  end

  // Truncating mean of the full window.
  function automatic logic [7:0] window_mean(input logic [SUM_W-1:0] s);
    return 8'(s >> DEPTH_LOG2);
  endfunction

  logic [7:0]       buf_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [SUM_W-1:0] sum_q, sum_d, oldest;
  logic             avg_valid_q, avg_valid_d;
  logic [7:0]       avg_q, avg_d;
  logic             eval_q;
  state_e           state_q;
  logic [3:0]       hold_q;
  logic             near_changed_q;
  logic             accept, full, miss_flush, flush;

  // Next window state assuming the current sample is accepted.
  always_comb begin
    accept      = sample_valid && !clear && (distance != 8'd0);
    full        = (fill_q == CNT_W'(DEPTH));
    oldest      = full ? SUM_W'(buf_q[ptr_q]) : '0;
    sum_d       = sum_q + SUM_W'(distance) - oldest;
    fill_d      = full ? fill_q : fill_q + 1'b1;
    ptr_d       = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    avg_valid_d = (fill_d == CNT_W'(DEPTH));
    avg_d       = avg_valid_d ? window_mean(sum_d) : 8'd0;
  end

`ifdef PROX_FILTER_MISS_FLUSH_EN
  localparam logic [3:0] MISS_LAST = 4'(MISS_LIMIT - 1);

  logic [3:0] miss_q;
  logic       zero_sample;

  assign zero_sample = sample_valid && !clear && (distance == 8'd0);
  assign miss_flush  = zero_sample && (miss_q == MISS_LAST);

  // Count consecutive no-echo samples; any echo restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_q <= '0;
    end else if (clear || miss_flush) begin
      miss_q <= '0;
    end else if (zero_sample) begin
      miss_q <= miss_q + 4'd1;
    end else if (accept) begin
      miss_q <= '0;
    end
  end
`else
  assign miss_flush = 1'b0;
`endif

  // A flush (explicit or from lost echoes) beats a coincident sample.
  assign flush = clear || miss_flush;

  // Window storage, running sum and registered average.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= 8'd0;
      ptr_q       <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      avg_valid_q <= 1'b0;
      avg_q       <= 8'd0;
      eval_q      <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= 8'd0;
      ptr_q       <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      avg_valid_q <= 1'b0;
      avg_q       <= 8'd0;
      eval_q      <= 1'b0;
    end else begin
      eval_q <= accept;
      if (accept) begin
        buf_q[ptr_q] <= distance;
        ptr_q        <= ptr_d;
        fill_q       <= fill_d;
        sum_q        <= sum_d;
        avg_valid_q  <= avg_valid_d;
        avg_q        <= avg_d;
      end
    end
  end

  // Alarm FSM: evaluates each fresh average one cycle after the window update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_FAR;
      hold_q         <= '0;
      near_changed_q <= 1'b0;
    end else begin
      near_changed_q <= 1'b0;
      if (flush) begin
        state_q        <= ST_FAR;
        hold_q         <= '0;
        near_changed_q <= (state_q == ST_NEAR);
      end else if (eval_q && avg_valid_q) begin
        case (state_q)
          ST_FAR: begin
            if (avg_q < NEAR_CM) begin
              if (hold_q == HOLD_LAST) begin
                state_q        <= ST_NEAR;
                hold_q         <= '0;
                near_changed_q <= 1'b1;
              end else begin
                hold_q <= hold_q + 4'd1;
              end
            end else begin
              hold_q <= '0;
            end
          end
          ST_NEAR: begin
            if (avg_q >= FAR_CM) begin
              if (hold_q == HOLD_LAST) begin
                state_q        <= ST_FAR;
                hold_q         <= '0;
                near_changed_q <= 1'b1;
              end else begin
                hold_q <= hold_q + 4'd1;
              end
            end else begin
              hold_q <= '0;
            end
          end
          default: begin
            state_q <= ST_FAR;
            hold_q  <= '0;
          end
        endcase
      end
    end
  end

  assign avg_valid    = avg_valid_q;
  assign avg_distance = avg_q;
  assign near         = (state_q == ST_NEAR);
  assign near_changed = near_changed_q;

endmodule
